// File: rtl/mini_proc_pkg.sv
// Shared definitions for the mini_processor ALU and its built-in self-test sequencer.
package mini_proc_pkg;

    localparam int unsigned DW = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Vector index layout: {ctrl[1:0], a[3:0], b[3:0]}
    localparam int unsigned          VEC_W    = 10;
    localparam logic [VEC_W-1:0]     LAST_VEC = 10'h3FF;
    localparam int unsigned          ERR_W    = 8;
    localparam logic [ERR_W-1:0]     ERR_MAX  = 8'hFF;
    localparam int unsigned          SETTLE_W = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StApply = 3'd1,
        StWait  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } bist_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit mini_processor ALU; carries and borrows are dropped.
module alu_ref_model
    import mini_proc_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    ctrl,
    output logic [DW-1:0] expected
);

    always_comb begin
        expected = '0;
        unique case (ctrl)
            OP_ADD:  expected = a + b;
            OP_SUB:  expected = a - b;
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_self_test.sv
// Self-test sequencer: sweeps all {ctrl, A, B} vectors through the ALU and records mismatches
// against the golden model, reporting status on registered outputs and the board LEDs.
module alu_self_test
    import mini_proc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    alu_result,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [1:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             fail_seen,
    output logic [3:0]       led
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

    bist_state_e         r_state;
    logic [VEC_W-1:0]    r_idx;
    logic [SETTLE_W-1:0] r_settle;
    logic [ERR_W-1:0]    r_err;
    logic [VEC_W-1:0]    r_first;
    logic                r_fail_seen;
    logic [DW-1:0]       r_alu_a;
    logic [DW-1:0]       r_alu_b;
    logic [1:0]          r_alu_ctrl;

    logic [DW-1:0]       w_expected;
    logic                w_mismatch;
    logic                w_last;
    logic [VEC_W-1:0]    w_idx_next;

    alu_ref_model u_ref (
        .a        (r_idx[7:4]),
        .b        (r_idx[3:0]),
        .ctrl     (r_idx[9:8]),
        .expected (w_expected)
    );

    always_comb begin
        w_mismatch = (alu_result != w_expected);
        w_last     = (r_idx == LAST_VEC);
        w_idx_next = r_idx + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_settle    <= '0;
            r_err       <= '0;
            r_first     <= '0;
            r_fail_seen <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_err       <= '0;
                        r_first     <= '0;
                        r_fail_seen <= 1'b0;
                        r_idx       <= '0;
                        r_alu_ctrl  <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_state     <= StApply;
                    end
                end
                StApply: begin
                    r_settle <= SETTLE_INIT;
                    r_state  <= StWait;
                end
                StWait: begin
                    r_settle <= r_settle - 4'd1;
                    // Guard against a zero load so a bad parameter cannot stall the sweep
                    if (r_settle <= 4'd1) begin
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_mismatch) begin
                        if (r_err != ERR_MAX) begin
                            r_err <= r_err + 8'd1;
                        end
                        if (!r_fail_seen) begin
                            r_first     <= r_idx;
                            r_fail_seen <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state <= StDone;
                    end else begin
                        // Operands for the next vector are launched on entry to APPLY
                        r_idx      <= w_idx_next;
                        r_alu_ctrl <= w_idx_next[9:8];
                        r_alu_a    <= w_idx_next[7:4];
                        r_alu_b    <= w_idx_next[3:0];
                        r_state    <= StApply;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        alu_a          = r_alu_a;
        alu_b          = r_alu_b;
        alu_ctrl       = r_alu_ctrl;
        busy           = (r_state == StApply) || (r_state == StWait) || (r_state == StCheck);
        done           = (r_state == StDone);
        pass           = done && (r_err == '0);
        err_count      = r_err;
        first_fail_vec = r_first;
        fail_seen      = r_fail_seen;
        led            = {r_fail_seen, pass, done, busy};
    end

endmodule

// File: tb/tb_alu_self_test.sv
// Randomised self-checking bench: a behavioural ALU with injectable faults and a two-cycle
// result latency drives the sequencer; expected status is derived from the fault set.
module tb_alu_self_test;

    localparam int unsigned SETTLE   = 1;
    localparam int          RUN_LEN  = 3073;
    localparam int          RUN_MAX  = 3300;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] alu_result;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_ctrl;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [9:0] first_fail_vec;
    logic       fail_seen;
    logic [3:0] led;
    logic [3:0] ref_exp;

    int n_checks = 0;
    int n_fail   = 0;

    bit         sub_as_add;
    logic [3:0] xor_tab [1024];
    logic [3:0] pipe1;
    logic [3:0] pipe2;

    always #5 clk = ~clk;

    alu_self_test #(
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .alu_result     (alu_result),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctrl       (alu_ctrl),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .fail_seen      (fail_seen),
        .led            (led)
    );

    alu_ref_model u_ref_chk (
        .a        (alu_a),
        .b        (alu_b),
        .ctrl     (alu_ctrl),
        .expected (ref_exp)
    );

    function automatic logic [3:0] golden(input logic [1:0] c, input logic [3:0] a,
                                          input logic [3:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (c)
            2'd0:    return 4'((ia + ib) % 16);
            2'd1:    return 4'((ia - ib + 16) % 16);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] bench_alu(input logic [9:0] v);
        logic [3:0] r;
        if (sub_as_add && v[9:8] == 2'd1) r = golden(2'd0, v[7:4], v[3:0]);
        else                              r = golden(v[9:8], v[7:4], v[3:0]);
        return r ^ xor_tab[v];
    endfunction

    // ALU with SETTLE+1 edges of latency: the most the sequencer is required to tolerate
    always @(posedge clk) begin
        pipe1 <= bench_alu({alu_ctrl, alu_a, alu_b});
        pipe2 <= pipe1;
    end
    assign alu_result = pipe2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_faults();
        sub_as_add = 1'b0;
        for (int v = 0; v < 1024; v++) xor_tab[v] = 4'd0;
    endtask

    task automatic add_random_faults(input int n);
        for (int i = 0; i < n; i++) begin
            xor_tab[$urandom_range(0, 1023)] = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic expect_status(output int errs, output int first, output bit seen);
        int cnt = 0;
        first = -1;
        for (int v = 0; v < 1024; v++) begin
            if (bench_alu(10'(v)) !== golden(2'(v >> 8), 4'(v >> 4), 4'(v))) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        seen  = (cnt > 0);
        errs  = (cnt > 255) ? 255 : cnt;
        if (first < 0) first = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_alu"},   {alu_ctrl, alu_a, alu_b}, 0);
        check_eq({tag, "_flags"}, {busy, done, pass, fail_seen}, 0);
        check_eq({tag, "_err"},   err_count, 0);
        check_eq({tag, "_first"}, first_fail_vec, 0);
        check_eq({tag, "_led"},   led, 0);
    endtask

    // Start is driven just after edge k, sampled at edge k+1; busy is expected after k+1
    // and done after k+3073. An optional start pulse lands mid-run and must be ignored.
    task automatic run_and_check(input string tag, input bit mid_start);
        int  exp_err;
        int  exp_first;
        bit  exp_seen;
        int  cyc = 0;
        int  busy_gaps = 0;
        int  sel [4];
        expect_status(exp_err, exp_first, exp_seen);
        sel[0] = 'h053;
        sel[1] = $urandom_range(0, 1023);
        sel[2] = $urandom_range(0, 1023);
        sel[3] = 'h3FF;
        @(posedge clk);
        #1 start = 1'b1;
        while (!done || cyc == 0) begin
            @(posedge clk);
            #1 cyc++;
            start = (mid_start && cyc == 1500) ? 1'b1 : 1'b0;
            if (cyc == 1) begin
                check_eq({tag, "_busy_k1"}, {busy, done}, 2'b10);
                check_eq({tag, "_clr_err"}, {fail_seen, err_count, first_fail_vec}, 0);
            end
            if (!done && !busy) busy_gaps++;
            for (int s = 0; s < 4; s++) begin
                if (cyc == 1 + 3 * sel[s]) begin
                    check_eq({tag, "_vec"}, {alu_ctrl, alu_a, alu_b}, sel[s]);
                    check_eq({tag, "_refmodel"}, ref_exp,
                             golden(2'(sel[s] >> 8), 4'(sel[s] >> 4), 4'(sel[s])));
                    if (sel[s] == 'h053) check_eq({tag, "_ref053"}, ref_exp, 4'b1000);
                end
            end
            if (cyc >= RUN_MAX) break;
        end
        start = 1'b0;
        check_eq({tag, "_done_time"}, cyc, RUN_LEN);
        check_eq({tag, "_busy_gaps"}, busy_gaps, 0);
        check_eq({tag, "_err"},   err_count, exp_err);
        check_eq({tag, "_first"}, first_fail_vec, exp_first);
        check_eq({tag, "_seen"},  fail_seen, exp_seen);
        check_eq({tag, "_pass"},  pass, (exp_err == 0));
        check_eq({tag, "_led"},   led, {exp_seen, (exp_err == 0), 1'b1, 1'b0});
        repeat (5) @(posedge clk);
        #1;
        check_eq({tag, "_hold"}, {done, busy, alu_ctrl, alu_a, alu_b}, {2'b10, 10'h3FF});
        check_eq({tag, "_hold_err"}, err_count, exp_err);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_hold", {busy, done}, 0);

        run_and_check("golden", 1'b1);

        clear_faults();
        sub_as_add = 1'b1;
        run_and_check("sub_add", 1'b0);
        check_eq("sub_add_224", err_count, 224);
        check_eq("sub_add_first", first_fail_vec, 10'h101);

        clear_faults();
        add_random_faults($urandom_range(1, 20));
        run_and_check("sparse", 1'b0);

        clear_faults();
        add_random_faults(700);
        run_and_check("saturate", 1'b0);
        check_eq("saturate_255", err_count, 255);

        // Reset during the APPLY of vector 500 discards the partial run
        clear_faults();
        add_random_faults(3);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3 * 500) @(posedge clk);
        #1;
        check_eq("abort_vec", {alu_ctrl, alu_a, alu_b}, 500);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle_zero("abort");

        clear_faults();
        run_and_check("after_abort", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
